// File: rtl/vga_offset_fetch_master.sv
// vga_offset_fetch_master: frame-synchronous Avalon-MM read master that pulls
// NUM_WORDS scroll offsets from memory on each vsync rising edge and commits
// them atomically to out_offsets.
// Optional feature macro: VGA_OFFSET_FETCH_TIMEOUT_EN adds a waitrequest
// watchdog that aborts a stalled fetch after TIMEOUT_CYCLES and sets timeout_err.
module vga_offset_fetch_master #(
    parameter int unsigned          ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR      = '0,
    parameter int unsigned          NUM_WORDS      = 2,
    parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      vsync,
    input  logic                      err_clear,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_read,
    input  logic [31:0]               avm_readdata,
    input  logic                      avm_waitrequest,
    output logic [32*NUM_WORDS-1:0]   out_offsets,
    output logic                      update,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_W-1:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e                           state_q, state_d;
    logic                             vsync_dly_q, vsync_dly_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic                             read_q, read_d;
    logic [NUM_WORDS-1:0][31:0]       shadow_q, shadow_d;
    logic [32*NUM_WORDS-1:0]          out_q, out_d;
    logic                             update_q, update_d;
    logic                             busy_q, busy_d;
    logic                             overrun_q, overrun_d;
    logic                             start_c;
    logic                             accept_c;

`ifdef VGA_OFFSET_FETCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]                  to_cnt_q, to_cnt_d;
    logic                             timeout_q, timeout_d;
    logic                             stall_c;
`else
    logic                             unused_timeout_cfg_c;
    assign unused_timeout_cfg_c = (TIMEOUT_CYCLES == 0);
`endif

    // State and datapath registers; reset drops the bus request and discards all data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vsync_dly_q <= 1'b0;
            idx_q       <= '0;
            addr_q      <= '0;
            read_q      <= 1'b0;
            shadow_q    <= '0;
            out_q       <= '0;
            update_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_dly_q <= vsync_dly_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            update_q    <= update_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef VGA_OFFSET_FETCH_TIMEOUT_EN
    // Watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    // Next-state logic: vsync edge detect, fetch sequencing, commit and sticky errors
    always_comb begin
        state_d     = state_q;
        vsync_dly_d = vsync;
        idx_d       = idx_q;
        addr_d      = addr_q;
        read_d      = read_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        update_d    = 1'b0;
        overrun_d   = overrun_q;

        start_c  = vsync && !vsync_dly_q && enable;
        accept_c = read_q && !avm_waitrequest;

`ifdef VGA_OFFSET_FETCH_TIMEOUT_EN
        stall_c   = read_q && avm_waitrequest;
        to_cnt_d  = stall_c ? (to_cnt_q + TO_W'(1)) : '0;
        timeout_d = timeout_q;
        if (err_clear) begin
            timeout_d = 1'b0;
        end
`endif

        // A set in the same cycle as err_clear wins
        if (err_clear) begin
            overrun_d = 1'b0;
        end
        if (start_c && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    addr_d  = BASE_ALIGNED;
                    read_d  = 1'b1;
                end
            end
            S_READ: begin
                if (accept_c) begin
                    for (int i = 0; i < int'(NUM_WORDS); i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[i] = avm_readdata;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                        state_d = S_COMMIT;
                        read_d  = 1'b0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        addr_d = addr_q + ADDR_W'(4);
                    end
                end
`ifdef VGA_OFFSET_FETCH_TIMEOUT_EN
                else if (stall_c && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                    // Abort: partial shadow is never committed
                    state_d   = S_IDLE;
                    read_d    = 1'b0;
                    to_cnt_d  = '0;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_COMMIT: begin
                out_d    = shadow_q;
                update_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign out_offsets = out_q;
    assign update      = update_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
`ifdef VGA_OFFSET_FETCH_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_offset_fetch_master.sv
// Directed bench for vga_offset_fetch_master: inputs change 1 time unit after
// each rising edge, outputs are checked at the same point.
module tb_vga_offset_fetch_master;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        vsync;
    logic        err_clear;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [63:0] out_offsets;
    logic        update;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    logic [31:0] mem0;
    logic [31:0] mem1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    vga_offset_fetch_master #(
        .ADDR_W         (32),
        .BASE_ADDR      (32'h0000_0100),
        .NUM_WORDS      (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .vsync           (vsync),
        .err_clear       (err_clear),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .out_offsets     (out_offsets),
        .update          (update),
        .busy            (busy),
        .overrun         (overrun),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-word memory model
    always_comb begin
        case (avm_address)
            32'h0000_0100: avm_readdata = mem0;
            32'h0000_0104: avm_readdata = mem1;
            default:       avm_readdata = 32'hDEAD_BEEF;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; vsync = 1'b0; err_clear = 1'b0;
        avm_waitrequest = 1'b0;
        mem0 = 32'h0000_0040; mem1 = 32'h0000_0010;
        step(); step();
        chk("rst_read", 64'(avm_read), 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_out", out_offsets, 64'd0);
        chk("rst_update", 64'(update), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        reset = 1'b0;
        step();

        // vsync edge while disabled: nothing happens
        vsync = 1'b1;
        step();
        chk("dis_read", 64'(avm_read), 64'd0);
        chk("dis_busy", 64'(busy), 64'd0);
        vsync = 1'b0;
        step();

        // Zero-wait fetch
        enable = 1'b1; vsync = 1'b1;
        step();                                     // edge k
        chk("zw_k_read", 64'(avm_read), 64'd1);
        chk("zw_k_addr", 64'(avm_address), 64'h100);
        chk("zw_k_busy", 64'(busy), 64'd1);
        vsync = 1'b0;
        step();                                     // k+1
        chk("zw_k1_addr", 64'(avm_address), 64'h104);
        chk("zw_k1_read", 64'(avm_read), 64'd1);
        step();                                     // k+2
        chk("zw_k2_read", 64'(avm_read), 64'd0);
        chk("zw_k2_busy", 64'(busy), 64'd1);
        chk("zw_k2_update", 64'(update), 64'd0);
        chk("zw_k2_out", out_offsets, 64'd0);
        step();                                     // k+3
        chk("zw_k3_out", out_offsets, 64'h0000_0010_0000_0040);
        chk("zw_k3_update", 64'(update), 64'd1);
        chk("zw_k3_busy", 64'(busy), 64'd0);
        step();                                     // k+4
        chk("zw_k4_update", 64'(update), 64'd0);

        // Three waitrequest cycles on word 0
        mem0 = 32'h0000_0111; mem1 = 32'h0000_0222;
        vsync = 1'b1; avm_waitrequest = 1'b1;
        step();                                     // k
        vsync = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();                                 // k+1..k+3 stalled
            chk("ws_hold_addr", 64'(avm_address), 64'h100);
            chk("ws_hold_read", 64'(avm_read), 64'd1);
        end
        avm_waitrequest = 1'b0;
        step();                                     // k+4
        chk("ws_k4_addr", 64'(avm_address), 64'h104);
        step();                                     // k+5
        chk("ws_k5_read", 64'(avm_read), 64'd0);
        chk("ws_k5_update", 64'(update), 64'd0);
        step();                                     // k+6
        chk("ws_k6_update", 64'(update), 64'd1);
        chk("ws_k6_out", out_offsets, 64'h0000_0222_0000_0111);
        step();

        // Overrun: second vsync edge during fetch
        mem0 = 32'h0000_0AAA; mem1 = 32'h0000_0BBB;
        vsync = 1'b1;
        step();                                     // k
        vsync = 1'b0;
        step();                                     // k+1
        chk("ov_pre", 64'(overrun), 64'd0);
        vsync = 1'b1;
        step();                                     // k+2 start while busy
        chk("ov_set", 64'(overrun), 64'd1);
        vsync = 1'b0;
        step();                                     // k+3
        chk("ov_update", 64'(update), 64'd1);
        chk("ov_out", out_offsets, 64'h0000_0BBB_0000_0AAA);
        step();
        chk("ov_no_restart", 64'(busy), 64'd0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("ov_cleared", 64'(overrun), 64'd0);

        // err_clear coincident with a new overrun: set wins
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
        vsync = 1'b1; err_clear = 1'b1;
        step();
        vsync = 1'b0; err_clear = 1'b0;
        chk("ov_set_wins", 64'(overrun), 64'd1);
        step(); step();

`ifdef VGA_OFFSET_FETCH_TIMEOUT_EN
        // Watchdog abort after 8 stalled cycles
        mem0 = 32'h0000_0CCC; mem1 = 32'h0000_0DDD;
        vsync = 1'b1; avm_waitrequest = 1'b1;
        step();                                     // k
        vsync = 1'b0;
        for (int i = 1; i <= 7; i++) step();        // k+7
        chk("to_k7_read", 64'(avm_read), 64'd1);
        chk("to_k7_err", 64'(timeout_err), 64'd0);
        step();                                     // k+8
        chk("to_k8_read", 64'(avm_read), 64'd0);
        chk("to_k8_err", 64'(timeout_err), 64'd1);
        avm_waitrequest = 1'b0;
        step();
        chk("to_no_update", 64'(update), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_out_kept", out_offsets, 64'h0000_0BBB_0000_0AAA);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("to_cleared", 64'(timeout_err), 64'd0);
`endif

        // Reset in the middle of a stalled read
        vsync = 1'b1; avm_waitrequest = 1'b1;
        step();                                     // k
        vsync = 1'b0;
        chk("mr_read_before", 64'(avm_read), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_read_drop", 64'(avm_read), 64'd0);
        chk("mr_out_zero", out_offsets, 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0; avm_waitrequest = 1'b0;
        mem0 = 32'h1234_5678; mem1 = 32'h9ABC_DEF0;
        step();
        vsync = 1'b1;
        step();                                     // k
        chk("mr_k_addr", 64'(avm_address), 64'h100);
        chk("mr_k_read", 64'(avm_read), 64'd1);
        vsync = 1'b0;
        step(); step(); step();                     // k+3
        chk("mr_k3_update", 64'(update), 64'd1);
        chk("mr_k3_out", out_offsets, 64'h9ABC_DEF0_1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_offset_fetch_master.md
# vga_offset_fetch_master

Avalon-MM read master that fetches per-frame scroll offsets for the VGA pipeline from memory. On each rising edge of vertical sync it reads NUM_WORDS consecutive 32-bit words starting at BASE_ADDR, then commits them atomically to its output registers so the renderer never sees a half-updated set. It is the initiator counterpart to the CPU-written offset PIO registers: the game writes offsets into memory, and this block pulls them in frame-synchronously without CPU involvement.

## Interface
- ADDR_W, 32, Avalon master address width (bytes)
- BASE_ADDR, 0, byte address of word 0; bits [1:0] ignored (forced 0)
- NUM_WORDS, 2, words fetched per frame (1..16)
- TIMEOUT_CYCLES, 1024, waitrequest watchdog limit (only with VGA_OFFSET_FETCH_TIMEOUT_EN)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; arms fetch on vsync edges
- vsync  in  1  vertical sync, synchronous to clk, active-high
- err_clear  in  1  one-cycle pulse clearing overrun and timeout_err
- avm_address  out  ADDR_W  read byte address
- avm_read  out  1  read request
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
- avm_waitrequest  in  1  slave stall
- out_offsets  out  32*NUM_WORDS  committed offsets; word i at [32*i+31:32*i]
- update  out  1  one-cycle pulse on commit
- busy  out  1  high while not IDLE
- overrun  out  1  sticky: vsync edge arrived while busy
- timeout_err  out  1  sticky: fetch aborted by watchdog (0 when macro absent)

## Operation
- Reset values: avm_read 0, avm_address 0, out_offsets 0, update 0, busy 0, overrun 0, timeout_err 0, state IDLE, vsync_d 0.
- Edge detect: start = vsync && !vsync_d && enable, sampled at the clock edge.
- States: IDLE, READ, COMMIT.
- IDLE: on start -> READ, idx 0, avm_address = BASE_ADDR, avm_read 1.
- READ: avm_read held high, address stable while waitrequest is high. On acceptance (avm_read && !avm_waitrequest): shadow[idx] <= avm_readdata. If idx == NUM_WORDS-1 -> COMMIT, avm_read 0; else idx+1, address +4.
- Address arithmetic: BASE_ADDR + 4*idx modulo 2^ADDR_W (wraps silently).
- COMMIT: out_offsets <= shadow, update 1 for this cycle only, -> IDLE.
- start while busy: ignored, overrun <= 1. Set wins over simultaneous err_clear.
- enable deassert mid-fetch: current fetch completes and commits; only new starts are gated.
- Reset mid-fetch: avm_read drops immediately (async), shadow discarded, out_offsets returns to 0.

## Timing
- Edge k samples vsync rising: state READ and avm_read high after edge k.
- Zero-wait slave, NUM_WORDS=2: words accepted at edges k+1 and k+2; out_offsets and update valid after edge k+3 (update low after k+4). Latency = NUM_WORDS+1 cycles + total wait cycles.
- Each waitrequest cycle adds one cycle; avm_address/avm_read never change while stalled.
- busy high from after edge k through the COMMIT cycle inclusive.
- Earliest next start: the cycle after COMMIT (state IDLE) provided vsync has fallen and risen again.

## Configuration
- VGA_OFFSET_FETCH_TIMEOUT_EN defined: a counter counts consecutive cycles with avm_read && avm_waitrequest; cleared on each acceptance. On reaching TIMEOUT_CYCLES: avm_read 0, shadow discarded, out_offsets unchanged, no update pulse, timeout_err <= 1, -> IDLE.
- Undefined: no counter; block waits indefinitely on waitrequest; timeout_err tied 0.

## Test plan
- Reset then idle: all outputs 0; vsync edge with enable=0 -> no avm_read, busy stays 0.
- Zero-wait fetch: BASE_ADDR=0x100, memory 0x100=0x0000_0040, 0x104=0x0000_0010; vsync edge -> addresses 0x100, 0x104 issued, out_offsets=0x0000_0010_0000_0040, update single pulse at k+3.
- Waitrequest 3 cycles on word 0: address/read held stable 3 cycles, commit at k+6, data correct.
- Second vsync edge during fetch -> overrun=1, fetch unaffected; err_clear pulse -> overrun=0; err_clear coincident with new overrun -> overrun stays 1.
- Timeout (macro defined, TIMEOUT_CYCLES=8): waitrequest stuck high -> avm_read drops after 8 stalled cycles, timeout_err=1, out_offsets keeps previous value, no update.
- Reset asserted mid-READ: avm_read 0 same cycle, out_offsets 0; after release, next vsync edge fetches normally from BASE_ADDR.
